// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing one LED bank between several cores.
// Each owner holds the LEDs for a programmable slice, and Avalon-MM registers control and observe it.
module led_share_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter int          LED_WIDTH     = 18,
    parameter logic [31:0] SLICE_DEFAULT = 32'd50000000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [1:0]                     address,
    input  logic                           chipselect,
    input  logic                           write_n,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    readdata,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LED_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [LED_WIDTH-1:0]           out_port
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [LED_WIDTH-1:0]   outPort_q, outPort_d;
    logic [IDXW-1:0]        lastOwner_q, lastOwner_d;
    logic [31:0]            count_q, count_d;

    logic                   ctrlEn_q;
    logic                   ctrlFreeze_q;
    logic [31:0]            slice_q;
    logic [LED_WIDTH-1:0]   idlePat_q;

    logic                   regWrite;
    logic [NUM_REQ-1:0]     candidates;
    logic                   rrFound;
    logic [IDXW-1:0]        rrWinner;
    logic [IDXW-1:0]        rrIdx;
    logic [NUM_REQ-1:0]     winnerOneHot;
    logic                   ownerReq;
    logic [LED_WIDTH-1:0]   ownerData;

    assign regWrite = chipselect && !write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrlEn_q     <= 1'b1;
            ctrlFreeze_q <= 1'b0;
            slice_q      <= SLICE_DEFAULT;
            idlePat_q    <= '0;
        end else if (regWrite) begin
            case (address)
                2'd0: begin
                    ctrlEn_q     <= writedata[0];
                    ctrlFreeze_q <= writedata[1];
                end
                2'd1: slice_q   <= (writedata == 32'd0) ? 32'd1 : writedata;
                2'd3: idlePat_q <= writedata[LED_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // The current owner is masked out, so one search serves both the initial grant and hand-over.
    always_comb begin
        candidates = req & ~grant_q;
        rrFound    = 1'b0;
        rrWinner   = lastOwner_q;
        rrIdx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rrIdx = IDXW'((int'(lastOwner_q) + k) % NUM_REQ);
            if (!rrFound && candidates[rrIdx]) begin
                rrFound  = 1'b1;
                rrWinner = rrIdx;
            end
        end
        winnerOneHot           = '0;
        winnerOneHot[rrWinner] = 1'b1;
    end

    always_comb begin
        ownerData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lastOwner_q == IDXW'(i)) begin
                ownerData = req_data[i*LED_WIDTH +: LED_WIDTH];
            end
        end
        ownerReq = |(req & grant_q);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        outPort_d   = outPort_q;
        lastOwner_d = lastOwner_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                grant_d   = '0;
                outPort_d = idlePat_q;
                if (ctrlEn_q && rrFound) begin
                    state_d     = OWN;
                    grant_d     = winnerOneHot;
                    lastOwner_d = rrWinner;
                    count_d     = slice_q - 32'd1;
                end
            end
            OWN: begin
                outPort_d = ownerData;
                count_d   = (count_q == 32'd0) ? 32'd0 : count_q - 32'd1;
                if (!ctrlEn_q) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (!ownerReq) begin
                    if (rrFound) begin
                        grant_d     = winnerOneHot;
                        lastOwner_d = rrWinner;
                        count_d     = slice_q - 32'd1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (count_q == 32'd0 && !ctrlFreeze_q && rrFound) begin
                    grant_d     = winnerOneHot;
                    lastOwner_d = rrWinner;
                    count_d     = slice_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            outPort_q   <= '0;
            lastOwner_q <= IDXW'(NUM_REQ - 1);
            count_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            outPort_q   <= outPort_d;
            lastOwner_q <= lastOwner_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[1:0] = {ctrlFreeze_q, ctrlEn_q};
            2'd1: readdata = slice_q;
            2'd2: begin
                readdata[NUM_REQ-1:0]    = grant_q;
                readdata[8]              = (state_q == OWN);
                readdata[16 +: NUM_REQ]  = req;
            end
            2'd3: readdata[LED_WIDTH-1:0] = idlePat_q;
            default: ;
        endcase
    end

    assign grant    = grant_q;
    assign out_port = outPort_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter: stimulus pushes cycle-stamped expectations,
// and a negedge monitor pops and compares them against the DUT.
module tb_led_share_arbiter;

    typedef enum {K_GRANT, K_OUT, K_RD} kind_t;
    typedef struct {
        int          cycle;
        kind_t       kind;
        string       name;
        logic [31:0] value;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  req;
    logic [71:0] req_data;
    logic [3:0]  grant;
    logic [17:0] out_port;

    logic [17:0] dat [4];
    exp_t        expQ[$];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    led_share_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .out_port   (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one expectation against whatever the DUT shows at this negedge.
    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        case (e.kind)
            K_GRANT: act = {28'd0, grant};
            K_OUT:   act = {14'd0, out_port};
            default: act = readdata;
        endcase
        total++;
        if (e.cycle != cyc) begin
            bad++;
            $display("[TB] FAIL %s: missed check cycle %0d (now %0d)", e.name, e.cycle, cyc);
        end else if (act !== e.value) begin
            bad++;
            $display("[TB] FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", e.name, cyc, act, e.value);
        end
    endtask

    always @(negedge clk) begin
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].cycle <= cyc) begin
                checkOutput(expQ[i]);
                expQ.delete(i);
            end
        end
    end

    task automatic pushExp(input int delta, input kind_t k, input string n, input logic [31:0] v);
        exp_t e;
        e.cycle = cyc + delta;
        e.kind  = k;
        e.name  = n;
        e.value = v;
        expQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req      = r;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
    endtask

    task automatic avWrite(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    function automatic int ownerAt(input int k);
        return (k == 0) ? 0 : (((k - 1) / 4 + 1) % 4);
    endfunction

    initial begin
        logic [3:0] oh;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        dat[0] = 18'h00F0F;
        dat[1] = 18'h11111;
        dat[2] = 18'h22222;
        dat[3] = 18'h33333;
        applyStimulus(4'b0000);
        tick(2);
        pushExp(0, K_GRANT, "reset_grant", 32'h0);
        pushExp(0, K_OUT, "reset_out", 32'h0);
        tick(1);
        reset_n = 1'b1;

        // Reset register values and idle pattern
        address = 2'd1; pushExp(0, K_RD, "slice_default", 32'd50000000); tick(1);
        address = 2'd0; pushExp(0, K_RD, "ctrl_default", 32'h1); tick(1);
        address = 2'd2; pushExp(0, K_RD, "status_idle", 32'h0); tick(1);
        avWrite(2'd3, 32'h2AAAA);
        pushExp(0, K_OUT, "idle_pat_before", 32'h0);
        pushExp(1, K_OUT, "idle_pat_after", 32'h2AAAA);
        address = 2'd3; pushExp(0, K_RD, "idle_pat_read", 32'h2AAAA);
        tick(2);

        // Single requester holds indefinitely
        avWrite(2'd1, 32'd4);
        applyStimulus(4'b0001);
        pushExp(1, K_GRANT, "single_grant", 32'h1);
        pushExp(1, K_OUT, "single_out_lag", 32'h2AAAA);
        pushExp(2, K_OUT, "single_out", 32'h00F0F);
        pushExp(10, K_GRANT, "single_hold10", 32'h1);
        pushExp(20, K_GRANT, "single_hold20", 32'h1);
        tick(21);
        address = 2'd2; pushExp(0, K_RD, "single_status", 32'h00010101);
        tick(1);

        // All four requesting: four-cycle slices in round-robin order
        applyStimulus(4'b1111);
        address = 2'd2;
        for (int k = 1; k <= 17; k++) begin
            oh = 4'b0001 << ownerAt(k);
            pushExp(k, K_GRANT, $sformatf("rr_grant_%0d", k), {28'd0, oh});
            pushExp(k, K_RD, $sformatf("rr_status_%0d", k), 32'h000F0100 | {28'd0, oh});
            pushExp(k, K_OUT, $sformatf("rr_out_%0d", k), {14'd0, dat[ownerAt(k - 1)]});
        end
        tick(18);

        // Owner 1 releases mid-slice, direct hand-over to 2, then everyone leaves
        applyStimulus(4'b1101);
        pushExp(1, K_GRANT, "release_handover", 32'h4);
        pushExp(1, K_OUT, "release_out_old", {14'd0, dat[1]});
        pushExp(2, K_OUT, "release_out_new", {14'd0, dat[2]});
        tick(3);
        applyStimulus(4'b0000);
        pushExp(1, K_GRANT, "all_drop_grant", 32'h0);
        pushExp(1, K_OUT, "all_drop_out_old", {14'd0, dat[2]});
        pushExp(2, K_OUT, "all_drop_idle_pat", 32'h2AAAA);
        tick(3);

        // Freeze holds owner 0, unfreeze rotates, disable idles
        avWrite(2'd0, 32'h3);
        applyStimulus(4'b0011);
        pushExp(1, K_GRANT, "freeze_grant", 32'h1);
        pushExp(2, K_OUT, "freeze_out", {14'd0, dat[0]});
        pushExp(5, K_GRANT, "freeze_hold5", 32'h1);
        pushExp(10, K_GRANT, "freeze_hold10", 32'h1);
        pushExp(15, K_GRANT, "freeze_hold15", 32'h1);
        tick(16);
        avWrite(2'd0, 32'h1);
        pushExp(0, K_GRANT, "unfreeze_same_edge", 32'h1);
        pushExp(1, K_GRANT, "unfreeze_rotate", 32'h2);
        tick(2);
        avWrite(2'd0, 32'h0);
        pushExp(0, K_GRANT, "disable_same_edge", 32'h2);
        pushExp(1, K_GRANT, "disable_grant", 32'h0);
        pushExp(1, K_OUT, "disable_out_old", {14'd0, dat[1]});
        pushExp(2, K_OUT, "disable_idle_pat", 32'h2AAAA);
        pushExp(3, K_GRANT, "disabled_stays", 32'h0);
        tick(4);

        // Slice of zero stores one; grant alternates every cycle
        avWrite(2'd1, 32'd0);
        address = 2'd1; pushExp(0, K_RD, "slice_zero_read", 32'h1);
        tick(1);
        avWrite(2'd0, 32'h1);
        pushExp(0, K_GRANT, "alt_en_same_edge", 32'h0);
        pushExp(1, K_GRANT, "alt_grant1", 32'h1);
        pushExp(2, K_GRANT, "alt_grant2", 32'h2);
        pushExp(3, K_GRANT, "alt_grant3", 32'h1);
        pushExp(4, K_GRANT, "alt_grant4", 32'h2);
        pushExp(2, K_OUT, "alt_out2", {14'd0, dat[0]});
        pushExp(3, K_OUT, "alt_out3", {14'd0, dat[1]});
        pushExp(4, K_OUT, "alt_out4", {14'd0, dat[0]});
        tick(5);

        // Asynchronous reset while owning
        pushExp(0, K_GRANT, "async_reset_grant", 32'h0);
        pushExp(0, K_OUT, "async_reset_out", 32'h0);
        pushExp(1, K_GRANT, "in_reset_grant", 32'h0);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        address = 2'd1; pushExp(0, K_RD, "post_reset_slice", 32'd50000000); tick(1);
        address = 2'd0; pushExp(0, K_RD, "post_reset_ctrl", 32'h1); tick(1);

        for (int w = 0; w < 50 && expQ.size() > 0; w++) tick(1);
        while (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: never checked", expQ[0].name);
            void'(expQ.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
